reorder_buffer: RTL and testbench

In-order retirement buffer for the out-of-order core. It records each dispatched instruction's previously-mapped physical destination registers (RW and RS classes) and tracks completion from execute. It retires at most one instruction per cycle in program order. At retirement it returns the stale physical registers to the free register list over the commit return path (`return_r`/`r_addr`, `return_s`/`s_addr`).

---
 rtl/reorder_buffer.sv | 129 ++++++++++++
 tb/tb_reorder_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer. Holds each dispatched
// instruction's stale RW/RS physical registers, tracks completion, and
// retires one finished instruction per cycle in program order, handing the
// stale registers back to the free list.
module reorder_buffer #(
  parameter int DEPTH     = 16,
  parameter int NUM_D_REG = 64,
  parameter int NUM_S_REG = 32,
  localparam int TW = $clog2(DEPTH),
  localparam int RW = $clog2(NUM_D_REG),
  localparam int SW = $clog2(NUM_S_REG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic          alloc_use_rw,
  input  logic [RW-1:0] alloc_old_rw,
  input  logic          alloc_use_rs,
  input  logic [SW-1:0] alloc_old_rs,
  output logic          alloc_ready,
  output logic [TW-1:0] alloc_tag,
  input  logic          done_valid,
  input  logic [TW-1:0] done_tag,
  input  logic          flush,
  output logic          commit_valid,
  output logic          return_r,
  output logic [RW-1:0] r_addr,
  output logic          return_s,
  output logic [SW-1:0] s_addr,
  output logic          empty,
  output logic [TW:0]   count
);

  logic [TW-1:0] head_reg;
  logic [TW-1:0] tail_reg;
  logic [TW:0]   count_reg;

  // Flattened views of the per-entry state so the head slot can be selected.
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] done_vec;
  logic [DEPTH-1:0] use_rw_vec;
  logic [DEPTH-1:0] use_rs_vec;
  logic [RW-1:0]    old_rw_arr [DEPTH];
  logic [SW-1:0]    old_rs_arr [DEPTH];

  logic alloc_fire;

  assign alloc_ready  = (count_reg < (TW+1)'(DEPTH));
  assign alloc_tag    = tail_reg;
  assign empty        = (count_reg == '0);
  assign count        = count_reg;
  assign alloc_fire   = alloc_valid & alloc_ready & ~flush;

  // Retire only a finished head; a flush cancels retirement in its own cycle.
  assign commit_valid = valid_vec[head_reg] & done_vec[head_reg] & ~flush;
  assign return_r     = commit_valid & use_rw_vec[head_reg];
  assign return_s     = commit_valid & use_rs_vec[head_reg];
  assign r_addr       = old_rw_arr[head_reg];
  assign s_addr       = old_rs_arr[head_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic          valid_reg;
      logic          done_reg;
      logic          use_rw_reg;
      logic [RW-1:0] old_rw_reg;
      logic          use_rs_reg;
      logic [SW-1:0] old_rs_reg;

      // Entry lifecycle: allocate at tail, mark done from execute, free at commit.
      // Alloc and commit never hit the same slot: that needs count==0 or count==DEPTH.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          done_reg   <= 1'b0;
          use_rw_reg <= 1'b0;
          old_rw_reg <= '0;
          use_rs_reg <= 1'b0;
          old_rs_reg <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else if (alloc_fire && (tail_reg == TW'(gi))) begin
          valid_reg  <= 1'b1;
          done_reg   <= 1'b0;
          use_rw_reg <= alloc_use_rw;
          old_rw_reg <= alloc_old_rw;
          use_rs_reg <= alloc_use_rs;
          old_rs_reg <= alloc_old_rs;
        end else if (commit_valid && (head_reg == TW'(gi))) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else if (done_valid && (done_tag == TW'(gi)) && valid_reg) begin
          done_reg <= 1'b1;
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign done_vec[gi]   = done_reg;
      assign use_rw_vec[gi] = use_rw_reg;
      assign use_rs_vec[gi] = use_rs_reg;
      assign old_rw_arr[gi] = old_rw_reg;
      assign old_rs_arr[gi] = old_rs_reg;
    end
  endgenerate

  // Head/tail pointers wrap naturally at DEPTH; count tells full from empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc_fire) begin
        tail_reg <= tail_reg + TW'(1);
      end
      if (commit_valid) begin
        head_reg <= head_reg + TW'(1);
      end
      case ({alloc_fire, commit_valid})
        2'b10:   count_reg <= count_reg + (TW+1)'(1);
        2'b01:   count_reg <= count_reg - (TW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic, checked every
// cycle against a program-order queue model of the buffer.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int TW = $clog2(DEPTH);
  localparam int RW = 6;
  localparam int SW = 5;

  logic          clk;
  logic          rst;
  logic          alloc_valid;
  logic          alloc_use_rw;
  logic [RW-1:0] alloc_old_rw;
  logic          alloc_use_rs;
  logic [SW-1:0] alloc_old_rs;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          done_valid;
  logic [TW-1:0] done_tag;
  logic          flush;
  logic          commit_valid;
  logic          return_r;
  logic [RW-1:0] r_addr;
  logic          return_s;
  logic [SW-1:0] s_addr;
  logic          empty;
  logic [TW:0]   count;

  reorder_buffer #(.DEPTH(DEPTH), .NUM_D_REG(64), .NUM_S_REG(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_use_rw(alloc_use_rw), .alloc_old_rw(alloc_old_rw),
    .alloc_use_rs(alloc_use_rs), .alloc_old_rs(alloc_old_rs),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .done_valid(done_valid), .done_tag(done_tag), .flush(flush),
    .commit_valid(commit_valid), .return_r(return_r), .r_addr(r_addr),
    .return_s(return_s), .s_addr(s_addr), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tag;
    bit rw;
    int orw;
    bit rs;
    int ors;
    bit done;
  } ent_t;

  ent_t q[$];
  int   next_tag = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic step(bit do_check);
    bit ecv;
    bit acc;
    ent_t e;
    #1;
    ecv = (q.size() > 0) && q[0].done && !flush;
    if (do_check) begin
      check_eq("count", 32'(count), 32'(q.size()));
      check_eq("empty", 32'(empty), 32'(q.size() == 0));
      check_eq("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
      check_eq("alloc_tag", 32'(alloc_tag), 32'(next_tag));
      check_eq("commit_valid", 32'(commit_valid), 32'(ecv));
      check_eq("return_r", 32'(return_r), 32'(ecv && q[0].rw));
      check_eq("return_s", 32'(return_s), 32'(ecv && q[0].rs));
      if (ecv && q[0].rw) check_eq("r_addr", 32'(r_addr), 32'(q[0].orw));
      if (ecv && q[0].rs) check_eq("s_addr", 32'(s_addr), 32'(q[0].ors));
    end
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
      next_tag = 0;
    end else begin
      acc = alloc_valid && (q.size() < DEPTH);
      if (done_valid)
        foreach (q[i]) if (q[i].tag == int'(done_tag)) q[i].done = 1'b1;
      if (ecv) begin
        $display("commit tag %0d rw %0d/%0d rs %0d/%0d", q[0].tag, q[0].rw, q[0].orw, q[0].rs, q[0].ors);
        void'(q.pop_front());
      end
      if (acc) begin
        e.tag = next_tag; e.rw = alloc_use_rw; e.orw = int'(alloc_old_rw);
        e.rs = alloc_use_rs; e.ors = int'(alloc_old_rs); e.done = 1'b0;
        q.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; done_valid = 1'b0;
  endtask

  task automatic set_alloc(bit rw, int orw, bit rs, int ors);
    alloc_valid = 1'b1; alloc_use_rw = rw; alloc_old_rw = orw[RW-1:0];
    alloc_use_rs = rs; alloc_old_rs = ors[SW-1:0];
  endtask

  task automatic set_rand_alloc();
    set_alloc(1'($urandom), int'($urandom_range(63)), 1'($urandom), int'($urandom_range(31)));
  endtask

  task automatic set_done(int t);
    done_valid = 1'b1; done_tag = t[TW-1:0];
  endtask

  // Mark the oldest not-yet-done entry, if any.
  task automatic done_oldest();
    int t;
    t = -1;
    foreach (q[i]) if (t < 0 && !q[i].done) t = q[i].tag;
    if (t >= 0) set_done(t); else done_valid = 1'b0;
  endtask

  initial begin
    idle();
    alloc_use_rw = 0; alloc_old_rw = '0; alloc_use_rs = 0; alloc_old_rs = '0; done_tag = '0;
    rst = 1'b1;
    @(negedge clk);
    step(0);
    idle();

    // Reset then idle, with a stray done to slot 3.
    for (int i = 0; i < 10; i++) begin
      if (i == 4) set_done(3); else done_valid = 1'b0;
      step(1);
    end
    idle();

    // Single instruction.
    set_alloc(1, 5, 0, 0);
    check_eq("single_tag", 32'(alloc_tag), 32'd0);
    step(1);
    idle(); set_done(0); step(1);
    idle(); #1;
    check_eq("single_commit", 32'(commit_valid), 32'd1);
    check_eq("single_raddr", 32'(r_addr), 32'd5);
    step(1);
    check_eq("single_empty", 32'(empty), 32'd1);

    // Out-of-order completion.
    for (int i = 0; i < 3; i++) begin set_alloc(1, 10 + i, 1, 20 + i); step(1); end
    idle(); set_done(q[2].tag); step(1);
    idle(); set_done(q[1].tag); step(1);
    idle(); set_done(q[0].tag); step(1);
    idle();
    for (int i = 0; i < 5; i++) step(1);

    // Fill, overflow attempt, drain with allocs held high (wraps tail).
    for (int i = 0; i < DEPTH; i++) begin set_rand_alloc(); step(1); end
    check_eq("full_ready", 32'(alloc_ready), 32'd0);
    set_rand_alloc(); step(1);
    for (int i = 0; i < 40; i++) begin set_rand_alloc(); done_oldest(); step(1); end
    alloc_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin done_oldest(); step(1); end
    idle();

    // Flush with 6 entries, head done, concurrent alloc.
    for (int i = 0; i < 6; i++) begin set_rand_alloc(); step(1); end
    idle(); set_done(q[1].tag); step(1);
    set_done(q[2].tag); step(1);
    set_done(q[0].tag); step(1);
    idle(); flush = 1'b1; set_rand_alloc(); step(1);
    idle(); step(1);
    check_eq("flush_tag", 32'(alloc_tag), 32'd0);
    set_rand_alloc(); step(1);
    idle(); step(1);

    // Reset mid-stream with a done arriving.
    for (int i = 0; i < 4; i++) begin set_rand_alloc(); step(1); end
    idle(); set_done(q[2].tag); step(1);
    set_done(q[3].tag); step(1);
    rst = 1'b1; set_done(q[1].tag); set_rand_alloc(); step(1);
    idle(); step(1); step(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      idle();
      if ($urandom_range(99) < 60) set_rand_alloc();
      if ($urandom_range(99) < 70) begin
        if (q.size() > 0 && $urandom_range(3) != 0) set_done(q[$urandom_range(q.size() - 1)].tag);
        else set_done(int'($urandom_range(DEPTH - 1)));
      end
      if ($urandom_range(99) < 2) flush = 1'b1;
      step(1);
    end
    idle();
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
